// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter
// Purpose  : Shares the single GPR write port between pipeline write-back
//            and a FIFO-buffered auxiliary requester. Reports pending
//            buffered destinations to ID and requests a stall on starvation.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pipe_we,
  input  logic [4:0]  i_pipe_wa,
  input  logic [31:0] i_pipe_wd,
  input  logic        i_aux_valid,
  output logic        o_aux_ready,
  input  logic [4:0]  i_aux_wa,
  input  logic [31:0] i_aux_wd,
  output logic        o_gpr_we,
  output logic [4:0]  o_gpr_wa,
  output logic [31:0] o_gpr_wd,
  input  logic [4:0]  i_rs_q,
  input  logic [4:0]  i_rt_q,
  output logic        o_rs_pending,
  output logic        o_rt_pending,
  output logic        o_pipe_stall
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam int c_SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_SC_W-1:0]  c_SMAX = c_SC_W'(STARVE_MAX);

  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_SC_W-1:0]  r_starve;
  logic [DEPTH-1:0]   r_vld;
  logic [4:0]         r_mem_wa [DEPTH];
  logic [31:0]        r_mem_wd [DEPTH];

  logic w_pipe_wr;
  logic w_deq;
  logic w_enq;
  logic w_rs_hit;
  logic w_rt_hit;

  // A pipeline write to r0 is no write at all; nothing reaches the port in reset.
  assign w_pipe_wr   = i_pipe_we && (i_pipe_wa != 5'd0) && !reset;
  assign w_deq       = !w_pipe_wr && (r_count != '0) && !reset;
  assign o_aux_ready = (r_count != c_FULL);
  // Requests to r0 are accepted (handshake completes) but never stored.
  assign w_enq       = i_aux_valid && o_aux_ready && (i_aux_wa != 5'd0);
  assign o_pipe_stall = (r_starve == c_SMAX);

  // Pointer, occupancy and entry-valid bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_deq) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_enq) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage; contents are only meaningful where r_vld is set.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_wa[r_wr_ptr] <= i_aux_wa;
      r_mem_wd[r_wr_ptr] <= i_aux_wd;
    end
  end

  // Saturating count of consecutive cycles the FIFO head lost the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if ((r_count == '0) || w_deq) begin
      r_starve <= '0;
    end else if (w_pipe_wr && (r_starve != c_SMAX)) begin
      r_starve <= r_starve + c_SC_W'(1);
    end
  end

  // Strict-priority write port mux: pipeline, then FIFO head, else idle.
  always_comb begin
    o_gpr_we = 1'b0;
    o_gpr_wa = 5'd0;
    o_gpr_wd = 32'd0;
    if (w_pipe_wr) begin
      o_gpr_we = 1'b1;
      o_gpr_wa = i_pipe_wa;
      o_gpr_wd = i_pipe_wd;
    end else if (w_deq) begin
      o_gpr_we = 1'b1;
      o_gpr_wa = r_mem_wa[r_rd_ptr];
      o_gpr_wd = r_mem_wd[r_rd_ptr];
    end
  end

  // Source-register hazard compare against every buffered entry, head included.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_mem_wa[i] == i_rs_q)) w_rs_hit = 1'b1;
      if (r_vld[i] && (r_mem_wa[i] == i_rt_q)) w_rt_hit = 1'b1;
    end
    o_rs_pending = w_rs_hit && (i_rs_q != 5'd0);
    o_rt_pending = w_rt_hit && (i_rt_q != 5'd0);
  end

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_arbiter
// Purpose  : Self-checking bench for gpr_wb_arbiter: directed vector table,
//            mid-cycle reset sequence and randomized traffic vs. a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

  localparam int c_DEPTH = 4;
  localparam int c_SMAX  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_wa;
  logic [31:0] aux_wd;
  logic        gpr_we;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic        rs_pending;
  logic        rt_pending;
  logic        pipe_stall;

  int n_pass  = 0;
  int n_total = 0;

  gpr_wb_arbiter #(.DEPTH(c_DEPTH), .STARVE_MAX(c_SMAX)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_pipe_we    (pipe_we),
    .i_pipe_wa    (pipe_wa),
    .i_pipe_wd    (pipe_wd),
    .i_aux_valid  (aux_valid),
    .o_aux_ready  (aux_ready),
    .i_aux_wa     (aux_wa),
    .i_aux_wd     (aux_wd),
    .o_gpr_we     (gpr_we),
    .o_gpr_wa     (gpr_wa),
    .o_gpr_wd     (gpr_wd),
    .i_rs_q       (rs_q),
    .i_rt_q       (rt_q),
    .o_rs_pending (rs_pending),
    .o_rt_pending (rt_pending),
    .o_pipe_stall (pipe_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pwe;
    logic [4:0]  pwa;
    logic [31:0] pwd;
    logic        av;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_rsp;
    logic        e_rtp;
    logic        e_st;
  } vec_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  vec_t tv[$];
  ent_t mq[$];
  int   m_starve;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                     input logic av, input logic [4:0] awa, input logic [31:0] awd,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic rdy, input logic rsp, input logic rtp, input logic st);
    vec_t v;
    v.pwe = pwe; v.pwa = pwa; v.pwd = pwd; v.av = av; v.awa = awa; v.awd = awd;
    v.rs = rs; v.rt = rt; v.e_we = we; v.e_wa = wa; v.e_wd = wd;
    v.e_rdy = rdy; v.e_rsp = rsp; v.e_rtp = rtp; v.e_st = st;
    tv.push_back(v);
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                       input logic av, input logic [4:0] awa, input logic [31:0] awd,
                       input logic [4:0] rs, input logic [4:0] rt);
    pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
    aux_valid = av; aux_wa = awa; aux_wd = awd;
    rs_q = rs; rt_q = rt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mq.delete();
    m_starve = 0;
  endtask

  // Reference predictions from the queue model and current inputs.
  function automatic logic m_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[k]) if (mq[k].wa == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_check(input int cyc);
    logic        pw;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    pw = pipe_we && (pipe_wa != 5'd0);
    e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0;
    if (pw) begin
      e_we = 1'b1; e_wa = pipe_wa; e_wd = pipe_wd;
    end else if (mq.size() != 0) begin
      e_we = 1'b1; e_wa = mq[0].wa; e_wd = mq[0].wd;
    end
    chk($sformatf("rnd%0d gpr_we", cyc), {31'd0, gpr_we}, {31'd0, e_we});
    chk($sformatf("rnd%0d gpr_wa", cyc), {27'd0, gpr_wa}, {27'd0, e_wa});
    chk($sformatf("rnd%0d gpr_wd", cyc), gpr_wd, e_wd);
    chk($sformatf("rnd%0d aux_ready", cyc), {31'd0, aux_ready}, {31'd0, mq.size() != c_DEPTH});
    chk($sformatf("rnd%0d rs_pending", cyc), {31'd0, rs_pending}, {31'd0, m_pend(rs_q)});
    chk($sformatf("rnd%0d rt_pending", cyc), {31'd0, rt_pending}, {31'd0, m_pend(rt_q)});
    chk($sformatf("rnd%0d pipe_stall", cyc), {31'd0, pipe_stall}, {31'd0, m_starve == c_SMAX});
  endtask

  // Clock-edge update of the model, all decisions taken on pre-edge state.
  task automatic model_edge();
    logic pw;
    logic rdy;
    logic popped;
    int   sz;
    ent_t e;
    pw = pipe_we && (pipe_wa != 5'd0);
    sz = mq.size();
    rdy = (sz != c_DEPTH);
    popped = 1'b0;
    if (!pw && sz != 0) begin
      void'(mq.pop_front());
      popped = 1'b1;
    end
    if (sz == 0 || popped) m_starve = 0;
    else if (m_starve < c_SMAX) m_starve++;
    if (aux_valid && rdy && aux_wa != 5'd0) begin
      e.wa = aux_wa; e.wd = aux_wd;
      mq.push_back(e);
    end
  endtask

  initial begin
    int pct;

    // ---------------- reset state (pipe write requested during reset) -----
    reset = 1'b1;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    @(negedge clk);
    chk("rst gpr_we", {31'd0, gpr_we}, 32'd0);
    chk("rst aux_ready", {31'd0, aux_ready}, 32'd1);
    chk("rst pipe_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst rs_pending", {31'd0, rs_pending}, 32'd0);
    do_reset();

    // ---------------- directed vector table --------------------------------
    //   pwe pwa   pwd        av awa  awd      rs  rt   we wa  wd         rdy rsp rtp st
    add(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,  5'd0, 5'd0, 1, 5'd5, 32'h1234, 1, 0, 0, 0);
    add(0, 5'd0, 32'h0,    1, 5'd9, 32'hAA, 5'd9, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd9, 5'd9, 1, 5'd9, 32'hAA,   1, 1, 1, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd9, 5'd9, 0, 5'd0, 32'h0,    1, 0, 0, 0);
    add(1, 5'd7, 32'h700,  1, 5'd1, 32'h11, 5'd1, 5'd0, 1, 5'd7, 32'h700,  1, 0, 0, 0);
    add(1, 5'd7, 32'h700,  1, 5'd2, 32'h22, 5'd1, 5'd0, 1, 5'd7, 32'h700,  1, 1, 0, 0);
    add(1, 5'd7, 32'h700,  1, 5'd3, 32'h33, 5'd1, 5'd3, 1, 5'd7, 32'h700,  1, 1, 0, 0);
    add(1, 5'd7, 32'h700,  1, 5'd4, 32'h44, 5'd2, 5'd3, 1, 5'd7, 32'h700,  1, 1, 1, 0);
    add(1, 5'd7, 32'h700,  1, 5'd5, 32'h55, 5'd2, 5'd4, 1, 5'd7, 32'h700,  0, 1, 1, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd5, 5'd1, 1, 5'd1, 32'h11,   0, 0, 1, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd1, 5'd2, 1, 5'd2, 32'h22,   1, 0, 1, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd5, 5'd4, 1, 5'd3, 32'h33,   1, 0, 1, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd5, 5'd4, 1, 5'd4, 32'h44,   1, 0, 1, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd5, 5'd4, 0, 5'd0, 32'h0,    1, 0, 0, 0);
    // starvation: one buffered entry, pipeline holds the port for 8 cycles
    add(0, 5'd0, 32'h0,    1, 5'd6, 32'h66, 5'd6, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0);
    for (int i = 0; i < c_SMAX; i++)
      add(1, 5'd7, 32'h777, 0, 5'd0, 32'h0, 5'd6, 5'd0, 1, 5'd7, 32'h777, 1, 1, 0, 0);
    add(1, 5'd7, 32'h777,  0, 5'd0, 32'h0,  5'd6, 5'd0, 1, 5'd7, 32'h777,  1, 1, 0, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd6, 5'd0, 1, 5'd6, 32'h66,   1, 1, 0, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd6, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0);
    // register-zero handling on both sources
    add(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 5'd0, 5'd0, 0, 5'd0, 32'h0,  1, 0, 0, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0);
    add(0, 5'd0, 32'h0,    1, 5'd8, 32'h88, 5'd8, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0);
    add(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0,  5'd8, 5'd0, 1, 5'd8, 32'h88,   1, 1, 0, 0);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  5'd8, 5'd0, 0, 5'd0, 32'h0,    1, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].pwe, tv[i].pwa, tv[i].pwd, tv[i].av, tv[i].awa, tv[i].awd, tv[i].rs, tv[i].rt);
      @(negedge clk);
      chk($sformatf("vec%0d gpr_we", i), {31'd0, gpr_we}, {31'd0, tv[i].e_we});
      chk($sformatf("vec%0d gpr_wa", i), {27'd0, gpr_wa}, {27'd0, tv[i].e_wa});
      chk($sformatf("vec%0d gpr_wd", i), gpr_wd, tv[i].e_wd);
      chk($sformatf("vec%0d aux_ready", i), {31'd0, aux_ready}, {31'd0, tv[i].e_rdy});
      chk($sformatf("vec%0d rs_pending", i), {31'd0, rs_pending}, {31'd0, tv[i].e_rsp});
      chk($sformatf("vec%0d rt_pending", i), {31'd0, rt_pending}, {31'd0, tv[i].e_rtp});
      chk($sformatf("vec%0d pipe_stall", i), {31'd0, pipe_stall}, {31'd0, tv[i].e_st});
      @(posedge clk);
      #1;
    end

    // ---------------- asynchronous reset with 3 entries and stall high ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd7, 32'h7, 1'b1, 5'(10 + i), 32'(32'hA0 + i), 5'd10, 5'd12);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 32'd0, 5'd10, 5'd12);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("pre-rst pipe_stall", {31'd0, pipe_stall}, 32'd1);
    chk("pre-rst rs_pending", {31'd0, rs_pending}, 32'd1);
    chk("pre-rst rt_pending", {31'd0, rt_pending}, 32'd1);
    chk("pre-rst aux_ready", {31'd0, aux_ready}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst aux_ready", {31'd0, aux_ready}, 32'd1);
    chk("midrst rs_pending", {31'd0, rs_pending}, 32'd0);
    chk("midrst rt_pending", {31'd0, rt_pending}, 32'd0);
    chk("midrst pipe_stall", {31'd0, pipe_stall}, 32'd0);
    chk("midrst gpr_we", {31'd0, gpr_we}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d gpr_we", i), {31'd0, gpr_we}, 32'd0);
      chk($sformatf("postrst%0d rs_pending", i), {31'd0, rs_pending}, 32'd0);
      @(posedge clk);
      #1;
    end

    // ---------------- randomized traffic vs. queue model -------------------
    do_reset();
    for (int c = 0; c < 1600; c++) begin
      pct = ((c / 200) % 2 == 1) ? 88 : 35;
      drive($urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      model_check(c);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
